// File: rtl/ysyx_22050039_idu.sv
// Instruction decode/issue stage: decodes the RV64I subset, checks RAW hazards against a busy
// scoreboard, and issues a registered operand bundle to EXU over a valid/ready handshake.
`ifndef ysyx_22050039_FUNC_LEN
`define ysyx_22050039_FUNC_LEN 8
`endif
`ifndef ysyx_22050039_Addi
`define ysyx_22050039_Addi   1
`define ysyx_22050039_Jalr   2
`define ysyx_22050039_Sd     3
`define ysyx_22050039_Auipc  4
`define ysyx_22050039_Lui    5
`define ysyx_22050039_Jal    6
`define ysyx_22050039_Ebreak 7
`endif

module ysyx_22050039_idu #(
    parameter int XLEN     = 64,
    parameter int FUNC_LEN = `ysyx_22050039_FUNC_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_valid,
    output logic                inst_ready,
    input  logic [31:0]         inst,
    input  logic [XLEN-1:0]     inst_pc,
    output logic [4:0]          rs1_addr,
    output logic [4:0]          rs2_addr,
    input  logic [XLEN-1:0]     rs1_data,
    input  logic [XLEN-1:0]     rs2_data,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [FUNC_LEN-1:0] func,
    output logic [XLEN-1:0]     src1,
    output logic [XLEN-1:0]     src2,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     sdata,
    output logic [4:0]          rd,
    output logic                wen,
    input  logic                wb_valid,
    input  logic [4:0]          wb_rd,
    input  logic                redirect,
    output logic                invalid,
    output logic                halted
);

    localparam logic [FUNC_LEN-1:0] FuncAddi   = FUNC_LEN'(`ysyx_22050039_Addi);
    localparam logic [FUNC_LEN-1:0] FuncJalr   = FUNC_LEN'(`ysyx_22050039_Jalr);
    localparam logic [FUNC_LEN-1:0] FuncSd     = FUNC_LEN'(`ysyx_22050039_Sd);
    localparam logic [FUNC_LEN-1:0] FuncAuipc  = FUNC_LEN'(`ysyx_22050039_Auipc);
    localparam logic [FUNC_LEN-1:0] FuncLui    = FUNC_LEN'(`ysyx_22050039_Lui);
    localparam logic [FUNC_LEN-1:0] FuncJal    = FUNC_LEN'(`ysyx_22050039_Jal);
    localparam logic [FUNC_LEN-1:0] FuncEbreak = FUNC_LEN'(`ysyx_22050039_Ebreak);
    localparam logic [FUNC_LEN-1:0] FuncInv    = '1;

    typedef enum logic [1:0] {StRun, StWaitJmp, StHalt} state_e;

    state_e state_q;
    logic [31:0] busy_q, busy_d;

    logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_j;
    logic [FUNC_LEN-1:0] d_func;
    logic [XLEN-1:0] d_src1, d_src2, d_sdata;
    logic d_wen_raw, d_wen, use_rs1, use_rs2, is_jump, is_stop, is_inv;
    logic [4:0] d_rd;
    logic hazard, accept;

    assign rs1_addr = inst[19:15];
    assign rs2_addr = inst[24:20];

    assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_u = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        d_func    = FuncInv;
        d_src1    = '0;
        d_src2    = '0;
        d_sdata   = '0;
        d_wen_raw = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        is_jump   = 1'b0;
        is_inv    = 1'b1;
        if (inst == 32'h0010_0073) begin
            d_func = FuncEbreak;
            is_inv = 1'b0;
        end else begin
            case (inst[6:0])
                7'b0010011: if (inst[14:12] == 3'b000) begin
                    d_func = FuncAddi; d_src1 = rs1_data; d_src2 = imm_i;
                    d_wen_raw = 1'b1; use_rs1 = 1'b1; is_inv = 1'b0;
                end
                7'b1100111: if (inst[14:12] == 3'b000) begin
                    d_func = FuncJalr; d_src1 = rs1_data; d_src2 = imm_i;
                    d_wen_raw = 1'b1; use_rs1 = 1'b1; is_jump = 1'b1; is_inv = 1'b0;
                end
                7'b0100011: if (inst[14:12] == 3'b011) begin
                    d_func = FuncSd; d_src1 = rs1_data; d_src2 = imm_s; d_sdata = rs2_data;
                    use_rs1 = 1'b1; use_rs2 = 1'b1; is_inv = 1'b0;
                end
                7'b0010111: begin
                    d_func = FuncAuipc; d_src1 = imm_u; d_wen_raw = 1'b1; is_inv = 1'b0;
                end
                7'b0110111: begin
                    d_func = FuncLui; d_src1 = imm_u; d_wen_raw = 1'b1; is_inv = 1'b0;
                end
                7'b1101111: begin
                    d_func = FuncJal; d_src1 = imm_j; d_wen_raw = 1'b1;
                    is_jump = 1'b1; is_inv = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign is_stop = is_inv || (d_func == FuncEbreak);
    assign d_wen   = d_wen_raw && (inst[11:7] != 5'd0);
    assign d_rd    = d_wen ? inst[11:7] : 5'd0;

    // Busy bits reflect the registered scoreboard only; a same-cycle writeback does not bypass.
    assign hazard = (use_rs1 && busy_q[inst[19:15]]) || (use_rs2 && busy_q[inst[24:20]]);
    assign inst_ready = (state_q == StRun) && (!ex_valid || ex_ready) && !hazard;
    assign accept = inst_valid && inst_ready;
    assign halted = (state_q == StHalt);

    always_comb begin
        busy_d = busy_q;
        if (wb_valid) busy_d[wb_rd] = 1'b0;
        if (accept && d_wen) busy_d[inst[11:7]] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            case (state_q)
                StRun: begin
                    if (accept && is_stop) state_q <= StHalt;
                    else if (accept && is_jump) state_q <= StWaitJmp;
                end
                StWaitJmp: if (redirect) state_q <= StRun;
                default: state_q <= StHalt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            func     <= '0;
            src1     <= '0;
            src2     <= '0;
            pc       <= '0;
            sdata    <= '0;
            rd       <= '0;
            wen      <= 1'b0;
            invalid  <= 1'b0;
        end else begin
            invalid <= accept && is_inv;
            if (accept) begin
                ex_valid <= 1'b1;
                func     <= d_func;
                src1     <= d_src1;
                src2     <= d_src2;
                pc       <= inst_pc;
                sdata    <= d_sdata;
                rd       <= d_rd;
                wen      <= d_wen;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule
